// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory-stage controller.
// Opcode classes, in-band error codes and the controller state encoding.
package mem_stage_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OPCODE_LOAD   = 7'b0000011;
  localparam opcode_t OPCODE_STORE  = 7'b0100011;
  localparam opcode_t OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    MEM_ERR_NONE       = 2'd0,
    MEM_ERR_MISALIGNED = 2'd1,
    MEM_ERR_TIMEOUT    = 2'd2
  } mem_err_t;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_ctrl_state_t;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == OPCODE_LOAD) || (op == OPCODE_STORE);
  endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Loadable up-counter with clear/enable that flags when the count reaches TIMEOUT_CYCLES-1.
// The expire flag is registered alongside the count so it always describes count_q.
module mem_req_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          expire_o
);

  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire_q;

  // Clear dominates load, load dominates increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= (cnt_d == TERM);
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory pipeline stage controller: accepts execute results, sequences word loads/stores
// on a single variable-latency data port, and presents a one-entry registered writeback slot.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          TIMEOUT_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  opcode_t               ex_opcode,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_rs2_data,
  input  logic [REG_IDX_W-1:0]  ex_rd,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_IDX_W-1:0]  wb_rd,
  output logic                  wb_reg_we,
  output mem_err_t              wb_err
);

  mem_ctrl_state_t       state_q, state_d;
  logic                  dmem_req_q, dmem_req_d;
  logic                  dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [REG_IDX_W-1:0]  acc_rd_q, acc_rd_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [REG_IDX_W-1:0]  wb_rd_q, wb_rd_d;
  logic                  wb_reg_we_q, wb_reg_we_d;
  mem_err_t              wb_err_q, wb_err_d;

  logic accept_c;
  logic timer_clr_c;
  logic timer_en_c;
  logic timer_expire;

  // Accept only when idle and the writeback slot is free or being drained this cycle.
  assign ex_ready = (state_q == MEM_IDLE) && (!wb_valid_q || wb_ready);
  assign accept_c = ex_valid && ex_ready;

  mem_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (timer_clr_c),
    .en_i       (timer_en_c),
    .load_i     (1'b0),
    .load_val_i ('0),
    .expire_o   (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    acc_rd_d     = acc_rd_q;
    wb_valid_d   = wb_valid_q && !wb_ready;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_reg_we_d  = wb_reg_we_q;
    wb_err_d     = wb_err_q;
    timer_clr_c  = 1'b0;
    timer_en_c   = 1'b0;

    unique case (state_q)
      MEM_IDLE: begin
        if (accept_c) begin
          if (!is_mem_op(ex_opcode)) begin
            wb_valid_d  = 1'b1;
            wb_data_d   = ex_alu_result;
            wb_rd_d     = ex_rd;
            wb_reg_we_d = (ex_opcode != OPCODE_BRANCH);
            wb_err_d    = MEM_ERR_NONE;
          end else if (ex_alu_result[1:0] != 2'b00) begin
            // Faulting address is reported in place of a result.
            wb_valid_d  = 1'b1;
            wb_data_d   = ex_alu_result;
            wb_rd_d     = ex_rd;
            wb_reg_we_d = 1'b0;
            wb_err_d    = MEM_ERR_MISALIGNED;
          end else begin
            state_d      = MEM_ACCESS;
            dmem_req_d   = 1'b1;
            dmem_we_d    = (ex_opcode == OPCODE_STORE);
            dmem_addr_d  = ADDR_WIDTH'(ex_alu_result);
            dmem_wdata_d = ex_rs2_data;
            acc_rd_d     = ex_rd;
            timer_clr_c  = 1'b1;
          end
        end
      end

      MEM_ACCESS: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (dmem_ack) begin
          state_d     = MEM_IDLE;
          dmem_req_d  = 1'b0;
          wb_valid_d  = 1'b1;
          wb_rd_d     = acc_rd_q;
          wb_err_d    = MEM_ERR_NONE;
          wb_reg_we_d = !dmem_we_q;
          wb_data_d   = dmem_we_q ? '0 : dmem_rdata;
        end else begin
          timer_en_c = 1'b1;
          if (TIMEOUT_EN && timer_expire) begin
            state_d     = MEM_IDLE;
            dmem_req_d  = 1'b0;
            wb_valid_d  = 1'b1;
            wb_rd_d     = acc_rd_q;
            wb_err_d    = MEM_ERR_TIMEOUT;
            wb_reg_we_d = 1'b0;
            wb_data_d   = DATA_WIDTH'(dmem_addr_q);
          end
        end
      end

      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MEM_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      acc_rd_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_reg_we_q  <= 1'b0;
      wb_err_q     <= MEM_ERR_NONE;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      acc_rd_q     <= acc_rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_reg_we_q  <= wb_reg_we_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
  assign wb_reg_we  = wb_reg_we_q;
  assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed scenarios plus random traffic,
// expected writeback entries predicted from instruction class, alignment and memory latency.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  opcode_t     ex_opcode = '0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_rs2_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_we;
  mem_err_t    wb_err;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  bit ready_val = 1'b1;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];

  mem_stage_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .TIMEOUT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_we(wb_reg_we), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of one instruction given how long memory takes to answer.
  function automatic exp_t predict(input opcode_t op, input logic [31:0] alu, input logic [4:0] rd,
                                   input int n_wait, input logic [31:0] rdata);
    exp_t e;
    e.rd = rd;
    e.err = 2'd0;
    e.data = alu;
    e.we = 1'b0;
    if (op != OPCODE_LOAD && op != OPCODE_STORE) begin
      e.we = (op != OPCODE_BRANCH);
    end else if (alu % 4 != 0) begin
      e.err = 2'd1;
    end else if (n_wait >= TO) begin
      e.err = 2'd2;
    end else if (op == OPCODE_LOAD) begin
      e.data = rdata;
      e.we = 1'b1;
    end else begin
      e.data = 32'd0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rand_ready) wb_ready = ($urandom_range(0, 3) != 0);
    else wb_ready = ready_val;
  end

  // Monitor: pop and compare every entry as it is consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && wb_valid && !wb_ready) chk("ready_under_backpressure", 32'(ex_ready), 32'd0);
      if (!rst && wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb_entry", 32'(wb_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_reg_we", 32'(wb_reg_we), 32'(e.we));
          chk("wb_err", 32'(wb_err), 32'(e.err));
        end
      end
    end
  end

  // Present one instruction (called and returning at posedge+1); answers memory after n_wait cycles.
  task automatic issue(input opcode_t op, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input int n_wait, input logic [31:0] rdata,
                       output int stalls);
    bit accepted = 1'b0;
    bit done = 1'b0;
    int hi = 0;
    int exp_hi;
    stalls = 0;
    ex_opcode = op; ex_alu_result = alu; ex_rs2_data = rs2; ex_rd = rd; ex_valid = 1'b1;
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (ex_ready) accepted = 1'b1;
      else begin stalls++; @(posedge clk); #1; end
    end
    if (!accepted) begin
      chk("accept_timeout", 32'(accepted), 32'd1);
      ex_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(predict(op, alu, rd, n_wait, rdata));
    #1;
    ex_valid = 1'b0;
    dmem_ack = 1'b0;
    if (is_mem_op(op) && alu[1:0] == 2'b00) begin
      exp_hi = (n_wait + 1 < TO) ? n_wait + 1 : TO;
      for (int c = 1; c <= 64 && !done; c++) begin
        @(negedge clk);
        if (dmem_req) hi++;
        chk("ready_in_access", 32'(ex_ready), 32'd0);
        if (c == 1) begin
          chk("dmem_addr", dmem_addr, alu);
          chk("dmem_we", 32'(dmem_we), 32'(op == OPCODE_STORE));
          if (op == OPCODE_STORE) chk("dmem_wdata", dmem_wdata, rs2);
        end
        if (c == exp_hi) chk("dmem_addr_stable", dmem_addr, alu);
        if (c == n_wait + 1) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
        if (c == n_wait + 1 || c == TO) done = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
      end
      chk("req_cycles", 32'(hi), 32'(exp_hi));
    end
    chk("req_after_op", 32'(dmem_req), 32'd0);
    chk("wb_valid_after_op", 32'(wb_valid), 32'd1);
  endtask

  initial begin
    int st;
    opcode_t ops[6];
    ops = '{OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, 7'b0110011, 7'b0010011, 7'b0110111};

    // Reset and idle outputs
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_reg_we", 32'(wb_reg_we), 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back ALU ops with no bubbles
    ready_val = 1'b1;
    issue(7'b0110011, 32'h11, 32'h0, 5'd1, 0, 32'h0, st); chk("b2b_stall0", 32'(st), 32'd0);
    issue(7'b0110011, 32'h22, 32'h0, 5'd2, 0, 32'h0, st); chk("b2b_stall1", 32'(st), 32'd0);
    issue(7'b0110011, 32'h33, 32'h0, 5'd3, 0, 32'h0, st); chk("b2b_stall2", 32'(st), 32'd0);

    // Load with 3 wait cycles, store with same-cycle ack
    issue(OPCODE_LOAD, 32'h100, 32'h0, 5'd4, 3, 32'hDEADBEEF, st);
    issue(OPCODE_STORE, 32'h204, 32'hCAFEF00D, 5'd5, 0, 32'h0, st);

    // Misaligned, timeout, ack in the final timeout cycle
    issue(OPCODE_LOAD, 32'h102, 32'h0, 5'd6, 0, 32'h0, st);
    issue(OPCODE_LOAD, 32'h180, 32'h0, 5'd7, 10, 32'h0, st);
    issue(OPCODE_LOAD, 32'h184, 32'h0, 5'd8, TO - 1, 32'h0BADF00D, st);
    issue(OPCODE_BRANCH, 32'h40, 32'h0, 5'd9, 0, 32'h0, st);

    // Backpressure, then same-cycle replacement
    repeat (2) @(posedge clk);
    #1;
    ready_val = 1'b0; wb_ready = 1'b0;
    issue(7'b0110011, 32'hA5, 32'h0, 5'd10, 0, 32'h0, st);
    fork
      begin repeat (3) @(posedge clk); #1; ready_val = 1'b1; wb_ready = 1'b1; end
    join_none
    issue(7'b0110011, 32'h5A, 32'h0, 5'd11, 0, 32'h0, st);
    chk("replace_stalls", 32'(st), 32'd3);

    // Reset during access drops the request; a late ack is ignored
    repeat (2) @(posedge clk);
    #1;
    ex_opcode = OPCODE_LOAD; ex_alu_result = 32'h300; ex_rd = 5'd12; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_req", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_ready", 32'(ex_ready), 32'd1);

    // Random traffic
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      issue(ops[$urandom_range(0, 5)], a, $urandom, 5'($urandom), int'($urandom_range(0, 6)),
            $urandom, st);
      if ($urandom_range(0, 3) == 0) begin repeat ($urandom_range(1, 3)) @(posedge clk); #1; end
    end

    // Drain
    rand_ready = 1'b0; ready_val = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Controller for the memory pipeline stage. It accepts execute results over a valid/ready handshake and sequences word loads and stores to a single data-memory port with variable-latency acknowledge. It produces a one-entry registered writeback output. It also detects misaligned accesses and memory timeouts, and reports them in-band.

Parameters:
DATA_WIDTH, 32, data path width (matches riscv_pkg).
ADDR_WIDTH, 32, data-memory address width.
TIMEOUT_CYCLES, 16, maximum cycles dmem_req may stay unacknowledged; must be >= 1.
TIMEOUT_EN, 1, 0 disables the timeout (wait indefinitely for ack).

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous, active-high reset
ex_valid  input  1  execute stage presents an instruction
ex_ready  output  1  controller can accept this cycle
ex_opcode  input  opcode_t (7)  instruction opcode
ex_alu_result  input  DATA_WIDTH  ALU result / effective address
ex_rs2_data  input  DATA_WIDTH  store data
ex_rd  input  5  destination register
dmem_req  output  1  memory request, held until ack or timeout
dmem_we  output  1  1 = store, 0 = load
dmem_addr  output  ADDR_WIDTH  word-aligned address
dmem_wdata  output  DATA_WIDTH  store data
dmem_ack  input  1  memory completes the request this cycle
dmem_rdata  input  DATA_WIDTH  load data, valid with ack
wb_valid  output  1  writeback entry valid
wb_ready  input  1  writeback consumes the entry
wb_data  output  DATA_WIDTH  result value
wb_rd  output  5  destination register
wb_reg_we  output  1  entry writes the register file
wb_err  output  mem_err_t (2)  error code: 0 none, 1 misaligned, 2 timeout

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; timeout counter 0; dmem_req, dmem_we, wb_valid, wb_reg_we = 0; dmem_addr, dmem_wdata, wb_data, wb_rd = 0; wb_err = NONE.
- Reset mid-access drops dmem_req on the next edge. A later ack is ignored.
- FSM has two states: IDLE and ACCESS.
- ex_ready = (state == IDLE) && (!wb_valid || wb_ready). This is combinational. The transfer happens on ex_valid && ex_ready.
- Output register: wb_valid clears on wb_ready when no new entry loads. A new entry overwrites a consumed entry in the same cycle.
- Opcode classes: LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011.
- Non-memory accept:
  - Next cycle: wb_valid = 1, wb_data = ex_alu_result, wb_rd = ex_rd, wb_reg_we = (opcode != BRANCH), wb_err = NONE.
  - State stays IDLE. Throughput is 1 per cycle.
- Load/store accept with ex_alu_result[1:0] != 0:
  - No memory access.
  - Next cycle: wb_valid = 1, wb_err = MISALIGNED, wb_reg_we = 0, wb_data = ex_alu_result (the faulting address).
- Aligned load/store accept:
  - Capture addr, wdata, rd, and we (= STORE).
  - Next cycle: state = ACCESS, dmem_req = 1. The address and data outputs stay stable while dmem_req = 1.
- In ACCESS, with dmem_ack = 1:
  - Next cycle: dmem_req = 0, state = IDLE, wb_valid = 1, wb_err = NONE.
  - Load: wb_data = dmem_rdata, wb_reg_we = 1.
  - Store: wb_data = 0, wb_reg_we = 0.
- In ACCESS, without ack: the counter increments.
  - If TIMEOUT_EN and counter == TIMEOUT_CYCLES-1, then next cycle: dmem_req = 0, state = IDLE, wb_valid = 1, wb_err = TIMEOUT, wb_reg_we = 0, wb_data = address.
  - An ack in the final timeout cycle wins over the timeout.
- The counter clears on entry to ACCESS.
- The wb slot is guaranteed empty when an access completes, because accept required it free. There is no stall state.
- Latency:
  - Non-memory and misaligned: 1 cycle from accept to wb_valid.
  - Memory: 1 + N + 1 cycles, where N = wait cycles before ack; minimum 2.
- dmem_ack in IDLE is ignored.
- ex_valid during ACCESS is not accepted (ex_ready = 0).

Decomposition:
- riscv_pkg additions:
  - mem_err_t enum (MEM_ERR_NONE, MEM_ERR_MISALIGNED, MEM_ERR_TIMEOUT).
  - mem_ctrl_state_t enum (MEM_IDLE, MEM_ACCESS).
  - Opcode constants OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH.
- One sub-module is natural: mem_req_timer. It is a loadable up-counter with clear, enable and an expire flag, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
1. Reset: rst held 2 cycles, then released -> all outputs 0, ex_ready = 1. Assert rst during ACCESS -> dmem_req = 0 on the next edge.
2. Back-to-back ALU ops, opcode 0110011, results 0x11/0x22/0x33, wb_ready = 1 -> wb_data 0x11, 0x22, 0x33 on consecutive cycles, wb_reg_we = 1, ex_ready never drops.
3. Load, addr 0x100, ack after 3 wait cycles with rdata 0xDEADBEEF -> dmem_req high 4 cycles, addr stable at 0x100, wb_data = 0xDEADBEEF, wb_reg_we = 1, ex_ready = 0 throughout ACCESS.
4. Store, addr 0x204, rs2 0xCAFEF00D, same-cycle ack -> dmem_we = 1, wdata = 0xCAFEF00D, wb_valid with wb_reg_we = 0 two cycles after accept.
5. Load to addr 0x102 -> no dmem_req, wb_err = MISALIGNED, wb_data = 0x102. Load with no ack, TIMEOUT_CYCLES = 4 -> req high exactly 4 cycles, then wb_err = TIMEOUT. Ack in cycle 4 -> normal completion.
6. Backpressure: wb_ready = 0 with wb_valid held -> ex_ready = 0 and wb outputs stable. Raising wb_ready with ex_valid = 1 -> accept and replacement in the same cycle, with no bubble.
